fifo_wptr_full: RTL and testbench

FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

---
 rtl/fifo_wptr_full.sv | 88 ++++++++
 tb/tb_fifo_wptr_full.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag logic for an asynchronous FIFO. It synchronizes the Gray read
// pointer into wclk and generates the write enable, the address, and the full/level/overflow flags.
module fifo_wptr_full #(
    parameter int unsigned A_SIZE   = 4,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic              winc,
    input  logic              wovf_clr,
    input  logic [A_SIZE:0]   rptr_gray,
    output logic              wen,
    output logic [A_SIZE-1:0] waddr,
    output logic [A_SIZE:0]   wptr_gray,
    output logic              wfull,
    output logic              walmost_full,
    output logic [A_SIZE:0]   wlevel,
    output logic              woverflow
);

    localparam logic [A_SIZE:0] AfLevel = (A_SIZE + 1)'(AF_LEVEL);

    logic [A_SIZE:0] wq1_q, wq2_q;
    logic [A_SIZE:0] wbin_q, wbin_d;
    logic [A_SIZE:0] wgray_q, wgray_d;
    logic [A_SIZE:0] wlevel_q, wlevel_d;
    logic            wfull_q, wfull_d;
    logic            walmost_full_q, walmost_full_d;
    logic            woverflow_q, woverflow_d;
    logic [A_SIZE:0] rbin_s;
    logic [A_SIZE:0] full_cmp;

    assign wen          = winc & ~wfull_q;
    assign waddr        = wbin_q[A_SIZE-1:0];
    assign wptr_gray    = wgray_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = woverflow_q;

    // Full when the write pointer has lapped the synchronized read pointer exactly once.
    assign full_cmp = {~wq2_q[A_SIZE:A_SIZE-1], wq2_q[A_SIZE-2:0]};

    always_comb begin
        rbin_s         = '0;
        rbin_s[A_SIZE] = wq2_q[A_SIZE];
        for (int i = int'(A_SIZE) - 1; i >= 0; i--) begin
            rbin_s[i] = rbin_s[i+1] ^ wq2_q[i];
        end
    end

    always_comb begin
        wbin_d         = wbin_q + (A_SIZE + 1)'(wen);
        wgray_d        = wbin_d ^ (wbin_d >> 1);
        wfull_d        = (wgray_d == full_cmp);
        wlevel_d       = wbin_d - rbin_s;
        walmost_full_d = (wlevel_d >= AfLevel);
        woverflow_d    = woverflow_q;
        if (winc && wfull_q) begin
            woverflow_d = 1'b1;
        end else if (wovf_clr) begin
            woverflow_d = 1'b0;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wq1_q          <= '0;
            wq2_q          <= '0;
            wbin_q         <= '0;
            wgray_q        <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wlevel_q       <= '0;
            woverflow_q    <= 1'b0;
        end else begin
            wq1_q          <= rptr_gray;
            wq2_q          <= wq1_q;
            wbin_q         <= wbin_d;
            wgray_q        <= wgray_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wlevel_q       <= wlevel_d;
            woverflow_q    <= woverflow_d;
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full with A_SIZE=4 and AF_LEVEL=12.
module tb_fifo_wptr_full;

    logic       wclk;
    logic       wrst;
    logic       winc;
    logic       wovf_clr;
    logic [4:0] rptr_gray;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr_gray;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    int nvec = 0;
    int nerr = 0;

    fifo_wptr_full #(
        .A_SIZE  (4),
        .AF_LEVEL(12)
    ) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .winc        (winc),
        .wovf_clr    (wovf_clr),
        .rptr_gray   (rptr_gray),
        .wen         (wen),
        .waddr       (waddr),
        .wptr_gray   (wptr_gray),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wlevel      (wlevel),
        .woverflow   (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    // Asynchronous reset pulse placed mid-cycle; leaves the bench at posedge+1.
    task automatic pulse_reset();
        #3;
        wrst = 1'b1;
        rptr_gray = '0;
        winc = 1'b0;
        wovf_clr = 1'b0;
        #2;
        wrst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        wrst = 1'b0;
        winc = 1'b1;
        wovf_clr = 1'b0;
        rptr_gray = 5'b10101;
        #1;
        wrst = 1'b1;
        #1;
        nvec++;
        if ({wfull, walmost_full, woverflow, wlevel, wptr_gray, waddr} !== 20'h0) begin
            nerr++;
            $display("FAIL reset_outputs got %b expected all zero",
                     {wfull, walmost_full, woverflow, wlevel, wptr_gray, waddr});
        end
        nvec++;
        if (wen !== 1'b1) begin
            nerr++;
            $display("FAIL reset_wen got %b expected 1", wen);
        end
        step();
        step();
        rptr_gray = '0;
        winc = 1'b0;
        wrst = 1'b0;
        step();
        step();
        nvec++;
        if ({wlevel, wptr_gray, wfull} !== 11'h0) begin
            nerr++;
            $display("FAIL reset_release_idle got %b expected 0", {wlevel, wptr_gray, wfull});
        end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 17; k++) begin
            winc = 1'b1;
            #1;
            nvec++;
            if (waddr !== ((k <= 16) ? 4'(k - 1) : 4'd0)) begin
                nerr++;
                $display("FAIL fill_waddr k=%0d got %0d expected %0d", k, waddr,
                         (k <= 16) ? k - 1 : 0);
            end
            nvec++;
            if (wen !== (k <= 16)) begin
                nerr++;
                $display("FAIL fill_wen k=%0d got %b expected %b", k, wen, k <= 16);
            end
            step();
            nvec++;
            if (wlevel !== ((k <= 16) ? 5'(k) : 5'd16)) begin
                nerr++;
                $display("FAIL fill_wlevel k=%0d got %0d expected %0d", k, wlevel,
                         (k <= 16) ? k : 16);
            end
            nvec++;
            if (walmost_full !== (k >= 12)) begin
                nerr++;
                $display("FAIL fill_almost k=%0d got %b expected %b", k, walmost_full, k >= 12);
            end
            nvec++;
            if (wfull !== (k >= 16)) begin
                nerr++;
                $display("FAIL fill_full k=%0d got %b expected %b", k, wfull, k >= 16);
            end
            nvec++;
            if (woverflow !== (k == 17)) begin
                nerr++;
                $display("FAIL fill_ovf k=%0d got %b expected %b", k, woverflow, k == 17);
            end
        end
        nvec++;
        if (wptr_gray !== 5'b11000) begin
            nerr++;
            $display("FAIL fill_wptr_gray got %b expected 11000", wptr_gray);
        end
    endtask

    task automatic test_overflow();
        winc = 1'b0;
        wovf_clr = 1'b1;
        step();
        nvec++;
        if (woverflow !== 1'b0) begin
            nerr++;
            $display("FAIL ovf_clear got %b expected 0", woverflow);
        end
        wovf_clr = 1'b0;
        winc = 1'b1;
        step();
        nvec++;
        if (woverflow !== 1'b1) begin
            nerr++;
            $display("FAIL ovf_set got %b expected 1", woverflow);
        end
        nvec++;
        if ({wptr_gray, waddr, wlevel, wfull} !== {5'b11000, 4'd0, 5'd16, 1'b1}) begin
            nerr++;
            $display("FAIL ovf_hold_ptrs got %b expected %b", {wptr_gray, waddr, wlevel, wfull},
                     {5'b11000, 4'd0, 5'd16, 1'b1});
        end
        wovf_clr = 1'b1;
        step();
        nvec++;
        if (woverflow !== 1'b1) begin
            nerr++;
            $display("FAIL ovf_set_wins got %b expected 1", woverflow);
        end
        winc = 1'b0;
        step();
        wovf_clr = 1'b0;
        nvec++;
        if (woverflow !== 1'b0) begin
            nerr++;
            $display("FAIL ovf_clear2 got %b expected 0", woverflow);
        end
    endtask

    task automatic test_read_sync();
        rptr_gray = 5'b00001;
        for (int e = 1; e <= 3; e++) begin
            step();
            nvec++;
            if (wfull !== (e < 3)) begin
                nerr++;
                $display("FAIL sync_full edge=%0d got %b expected %b", e, wfull, e < 3);
            end
            nvec++;
            if (wlevel !== ((e < 3) ? 5'd16 : 5'd15)) begin
                nerr++;
                $display("FAIL sync_level edge=%0d got %0d expected %0d", e, wlevel,
                         (e < 3) ? 16 : 15);
            end
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        for (int k = 1; k <= 20; k++) begin
            winc = 1'b1;
            #1;
            nvec++;
            if (waddr !== 4'((k - 1) % 16) || wen !== 1'b1) begin
                nerr++;
                $display("FAIL wrap_addr k=%0d got %0d/%b expected %0d/1", k, waddr, wen,
                         (k - 1) % 16);
            end
            step();
            nvec++;
            if (wfull !== 1'b0 || wlevel !== ((k < 3) ? 5'(k) : 5'd3)) begin
                nerr++;
                $display("FAIL wrap_level k=%0d got full=%b lvl=%0d expected full=0 lvl=%0d",
                         k, wfull, wlevel, (k < 3) ? k : 3);
            end
            rptr_gray = gray(5'(k));
        end
        winc = 1'b0;
        nvec++;
        if (wptr_gray !== 5'b11110) begin
            nerr++;
            $display("FAIL wrap_gray got %b expected 11110", wptr_gray);
        end
        for (int e = 1; e <= 3; e++) begin
            step();
            nvec++;
            if (wlevel !== 5'(3 - e) || wfull !== 1'b0) begin
                nerr++;
                $display("FAIL wrap_drain e=%0d got lvl=%0d full=%b expected lvl=%0d full=0",
                         e, wlevel, wfull, 3 - e);
            end
        end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        winc = 1'b1;
        for (int k = 1; k <= 7; k++) step();
        nvec++;
        if (wlevel !== 5'd7) begin
            nerr++;
            $display("FAIL arst_pre_level got %0d expected 7", wlevel);
        end
        #2;
        wrst = 1'b1;
        #1;
        nvec++;
        if ({wfull, walmost_full, woverflow, wlevel, wptr_gray, waddr} !== 20'h0) begin
            nerr++;
            $display("FAIL arst_outputs got %b expected all zero",
                     {wfull, walmost_full, woverflow, wlevel, wptr_gray, waddr});
        end
        nvec++;
        if (wen !== 1'b1) begin
            nerr++;
            $display("FAIL arst_wen got %b expected 1", wen);
        end
        #1;
        wrst = 1'b0;
        step();
        nvec++;
        if ({waddr, wlevel, wptr_gray} !== {4'd1, 5'd1, 5'b00001}) begin
            nerr++;
            $display("FAIL arst_resume got %b expected %b", {waddr, wlevel, wptr_gray},
                     {4'd1, 5'd1, 5'b00001});
        end
        winc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_read_sync();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
